// File: rtl/color_pkg.sv
// Shared constants and helpers for the CIE XYZ -> 8-bit RGB pipeline.
// Inputs are fixed point with 1,000,000 = full scale; coefficients are x1/10000.
package color_pkg;

    localparam int IN_W   = 32;
    localparam int COEF_W = 16;
    localparam int PROD_W = 48;
    localparam int SUM_W  = 50;
    localparam int VAL_W  = 20;
    localparam int PIX_W  = 8;

    localparam int unsigned DIVISOR    = 10000;
    localparam int unsigned FULL_SCALE = 1000000;
    localparam int unsigned ROUND_HALF = FULL_SCALE / 2;
    localparam int unsigned PIX_MAX    = 255;

    localparam logic signed [COEF_W-1:0] C_RX =  16'sd32406;
    localparam logic signed [COEF_W-1:0] C_RY = -16'sd15372;
    localparam logic signed [COEF_W-1:0] C_RZ = -16'sd4986;
    localparam logic signed [COEF_W-1:0] C_GX = -16'sd9689;
    localparam logic signed [COEF_W-1:0] C_GY =  16'sd18758;
    localparam logic signed [COEF_W-1:0] C_GZ =  16'sd415;
    localparam logic signed [COEF_W-1:0] C_BX =  16'sd557;
    localparam logic signed [COEF_W-1:0] C_BY = -16'sd2040;
    localparam logic signed [COEF_W-1:0] C_BZ =  16'sd10570;

    // Both operands widened first so the product is formed at full width.
    function automatic logic signed [PROD_W-1:0] mul_coef(
        input logic signed [IN_W-1:0]   a,
        input logic signed [COEF_W-1:0] c
    );
        logic signed [PROD_W-1:0] ae;
        logic signed [PROD_W-1:0] ce;
        ae = {{(PROD_W-IN_W){a[IN_W-1]}}, a};
        ce = {{(PROD_W-COEF_W){c[COEF_W-1]}}, c};
        return ae * ce;
    endfunction

    function automatic logic [PIX_W-1:0] denorm(input logic [VAL_W-1:0] v);
        logic [31:0] t;
        t = {{(32-VAL_W){1'b0}}, v} * PIX_MAX + ROUND_HALF;
        return PIX_W'(t / FULL_SCALE);
    endfunction

endpackage

// File: rtl/xyz_row_dot.sv
// One matrix row: registered products (S1), then registered sum/scale/clamp (S2).
module xyz_row_dot
    import color_pkg::*;
#(
    parameter logic signed [COEF_W-1:0] CX = '0,
    parameter logic signed [COEF_W-1:0] CY = '0,
    parameter logic signed [COEF_W-1:0] CZ = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic signed [IN_W-1:0]  x_i,
    input  logic signed [IN_W-1:0]  y_i,
    input  logic signed [IN_W-1:0]  z_i,
    output logic [VAL_W-1:0]        val_o,
    output logic                    clip_o
);

    localparam logic signed [SUM_W-1:0] DIV_S = SUM_W'(DIVISOR);
    localparam logic signed [SUM_W-1:0] FS_S  = SUM_W'(FULL_SCALE);

    logic signed [PROD_W-1:0] px_q, py_q, pz_q;
    logic signed [SUM_W-1:0]  sum_s, quot_s;
    logic [VAL_W-1:0]         val_d, val_q;
    logic                     clip_d, clip_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            px_q <= '0;
            py_q <= '0;
            pz_q <= '0;
        end else if (en_i) begin
            px_q <= mul_coef(x_i, CX);
            py_q <= mul_coef(y_i, CY);
            pz_q <= mul_coef(z_i, CZ);
        end
    end

    // Signed division truncates toward zero before the clamp is applied.
    always_comb begin
        sum_s  = $signed({{(SUM_W-PROD_W){px_q[PROD_W-1]}}, px_q})
               + $signed({{(SUM_W-PROD_W){py_q[PROD_W-1]}}, py_q})
               + $signed({{(SUM_W-PROD_W){pz_q[PROD_W-1]}}, pz_q});
        quot_s = sum_s / DIV_S;
        val_d  = quot_s[VAL_W-1:0];
        clip_d = 1'b0;
        if (quot_s[SUM_W-1]) begin
            val_d  = '0;
            clip_d = 1'b1;
        end else if (quot_s > FS_S) begin
            val_d  = VAL_W'(FULL_SCALE);
            clip_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            val_q  <= '0;
            clip_q <= 1'b0;
        end else if (en_i) begin
            val_q  <= val_d;
            clip_q <= clip_d;
        end
    end

    assign val_o  = val_q;
    assign clip_o = clip_q;

endmodule

// File: rtl/xyz_to_rgb_stream.sv
// Streaming XYZ -> 8-bit sRGB-linear converter: 3-stage pipeline with a single
// global advance, so a stalled output freezes every stage in place.
module xyz_to_rgb_stream
    import color_pkg::*;
#(
    parameter int CLIP_CNT_W = 16
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic signed [IN_W-1:0]  X_in,
    input  logic signed [IN_W-1:0]  Y_in,
    input  logic signed [IN_W-1:0]  Z_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [PIX_W-1:0]        R_out,
    output logic [PIX_W-1:0]        G_out,
    output logic [PIX_W-1:0]        B_out,
    output logic                    out_clip,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CLIP_CNT_W-1:0]   clip_cnt,
    input  logic                    clip_clr
);

    logic                  advance;
    logic [2:0]            vld_q;
    logic [VAL_W-1:0]      val_r, val_g, val_b;
    logic                  clip_r, clip_g, clip_b;
    logic [PIX_W-1:0]      r_q, g_q, b_q;
    logic                  clip_q;
    logic [CLIP_CNT_W-1:0] clip_cnt_d, clip_cnt_q;

    assign advance  = !vld_q[2] || out_ready;
    assign in_ready = advance;

    xyz_row_dot #(.CX(C_RX), .CY(C_RY), .CZ(C_RZ)) u_row_r (
        .clk_i(Clk), .rst_i(Reset), .en_i(advance),
        .x_i(X_in), .y_i(Y_in), .z_i(Z_in),
        .val_o(val_r), .clip_o(clip_r)
    );

    xyz_row_dot #(.CX(C_GX), .CY(C_GY), .CZ(C_GZ)) u_row_g (
        .clk_i(Clk), .rst_i(Reset), .en_i(advance),
        .x_i(X_in), .y_i(Y_in), .z_i(Z_in),
        .val_o(val_g), .clip_o(clip_g)
    );

    xyz_row_dot #(.CX(C_BX), .CY(C_BY), .CZ(C_BZ)) u_row_b (
        .clk_i(Clk), .rst_i(Reset), .en_i(advance),
        .x_i(X_in), .y_i(Y_in), .z_i(Z_in),
        .val_o(val_b), .clip_o(clip_b)
    );

    // vld_q[0]=S1, [1]=S2, [2]=S3; bubbles shift through like data.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vld_q <= '0;
        end else if (advance) begin
            vld_q <= {vld_q[1:0], in_valid};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
            clip_q <= 1'b0;
        end else if (advance) begin
            r_q    <= denorm(val_r);
            g_q    <= denorm(val_g);
            b_q    <= denorm(val_b);
            clip_q <= clip_r | clip_g | clip_b;
        end
    end

    always_comb begin
        clip_cnt_d = clip_cnt_q;
        if (clip_clr) begin
            clip_cnt_d = '0;
        end else if (vld_q[2] && out_ready && clip_q && !(&clip_cnt_q)) begin
            clip_cnt_d = clip_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            clip_cnt_q <= '0;
        end else begin
            clip_cnt_q <= clip_cnt_d;
        end
    end

    assign R_out     = r_q;
    assign G_out     = g_q;
    assign B_out     = b_q;
    assign out_clip  = clip_q;
    assign out_valid = vld_q[2];
    assign clip_cnt  = clip_cnt_q;

endmodule
